// File: rtl/fir_decim_quant.sv
// Purpose: keep every D-th wide signed FIR sample, round-half-up, shift, saturate to OWIDTH, buffer in a small FIFO.
// Latency: a kept sample accepted in cycle N shows dout_valid in cycle N+2 when the FIFO is empty.
// Backpressure: din_busy comes from registers only (FIFO count + stage-1 occupancy >= FDEPTH); there is no comb path from dout_busy.
// Ports: clk/rst (sync, active-high); decim = decimation factor (0 acts as 1);
//        din_valid/din_busy/din_data = input handshake; dout_valid/dout_busy/dout_data = output handshake;
//        sat_cnt = saturating count of clipped samples pushed into the FIFO.
module fir_decim_quant #(
  parameter int IWIDTH = 22,
  parameter int OWIDTH = 8,
  parameter int SHIFT  = 6,
  parameter int CWIDTH = 4,
  parameter int FDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CWIDTH-1:0] decim,
  input  logic              din_valid,
  output logic              din_busy,
  input  logic [IWIDTH-1:0] din_data,
  output logic              dout_valid,
  input  logic              dout_busy,
  output logic [OWIDTH-1:0] dout_data,
  output logic [15:0]       sat_cnt
);

  localparam int AW   = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CNTW = $clog2(FDEPTH + 1);
  localparam int RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;

  // Rounding offset, and the representable output range expressed at the intermediate width.
  localparam logic signed [IWIDTH:0] RND  = (SHIFT > 0) ? $signed((IWIDTH+1)'(1) << RSH) : '0;
  localparam logic signed [IWIDTH:0] QMAX = (IWIDTH+1)'((2 ** (OWIDTH-1)) - 1);
  localparam logic signed [IWIDTH:0] QMIN = ~QMAX;

  localparam logic [OWIDTH-1:0] SAT_POS = {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic [OWIDTH-1:0] SAT_NEG = {1'b1, {(OWIDTH-1){1'b0}}};

  // Decimation phase
  logic [CWIDTH-1:0] deff;
  logic [CWIDTH-1:0] phs;
  logic [CWIDTH:0]   phs_inc;
  logic              accept;
  logic              keep;

  assign deff    = (decim == '0) ? CWIDTH'(1) : decim;
  assign phs_inc = {1'b0, phs} + (CWIDTH+1)'(1);
  assign accept  = din_valid && !din_busy;
  assign keep    = accept && (phs == '0);

  // Quantizer: one extra bit of headroom so the rounding add cannot overflow.
  logic signed [IWIDTH:0] x_ext;
  logic signed [IWIDTH:0] r_val;
  logic signed [IWIDTH:0] q_val;
  logic [OWIDTH-1:0]      q_out;
  logic                   q_sat;

  assign x_ext = {din_data[IWIDTH-1], din_data};
  assign r_val = x_ext + RND;
  assign q_val = r_val >>> SHIFT;

  always_comb begin
    q_out = q_val[OWIDTH-1:0];
    q_sat = 1'b0;
    if (q_val > QMAX) begin
      q_out = SAT_POS;
      q_sat = 1'b1;
    end else if (q_val < QMIN) begin
      q_out = SAT_NEG;
      q_sat = 1'b1;
    end
  end

  // Stage 1 and output FIFO
  logic              s1_valid;
  logic [OWIDTH-1:0] s1_dat;
  logic              s1_sat;

  logic [OWIDTH-1:0] mem [FDEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNTW-1:0]   count;
  logic              push;
  logic              pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(FDEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // s1 is counted as occupied so that a sample accepted now always finds a FIFO slot two edges later.
  assign din_busy   = ({1'b0, count} + {{CNTW{1'b0}}, s1_valid}) >= (CNTW+1)'(FDEPTH);
  assign dout_valid = (count != '0);
  assign dout_data  = mem[rd_ptr];
  assign push       = s1_valid;
  assign pop        = dout_valid && !dout_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      phs      <= '0;
      s1_valid <= 1'b0;
      s1_dat   <= '0;
      s1_sat   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sat_cnt  <= '0;
      for (int i = 0; i < FDEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // A phase left out of range by a decim change wraps: that sample is dropped and phs restarts.
      if (accept) begin
        phs <= (phs_inc >= {1'b0, deff}) ? '0 : phs_inc[CWIDTH-1:0];
      end

      s1_valid <= keep;
      if (keep) begin
        s1_dat <= q_out;
        s1_sat <= q_sat;
      end

      if (push) begin
        mem[wr_ptr] <= s1_dat;
        wr_ptr      <= next_ptr(wr_ptr);
        if (s1_sat && (sat_cnt != 16'hFFFF)) begin
          sat_cnt <= sat_cnt + 16'd1;
        end
      end

      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end

      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decim_quant.sv
// Purpose: self-checking bench for fir_decim_quant (vector table, hand-written corner sequences, random run against a reference model).
// Latency: checks the two-cycle accept-to-output delay on single samples.
// Backpressure: exercises a held, a toggling and a random dout_busy against the din_busy rule.
module tb_fir_decim_quant;

  localparam int IW = 22;
  localparam int OW = 8;
  localparam int SH = 6;
  localparam int CW = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] decim;
  logic          din_valid;
  logic          din_busy;
  logic [IW-1:0] din_data;
  logic          dout_valid;
  logic          dout_busy;
  logic [OW-1:0] dout_data;
  logic [15:0]   sat_cnt;

  always #5 clk = ~clk;

  fir_decim_quant #(
    .IWIDTH(IW), .OWIDTH(OW), .SHIFT(SH), .CWIDTH(CW), .FDEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .decim     (decim),
    .din_valid (din_valid),
    .din_busy  (din_busy),
    .din_data  (din_data),
    .dout_valid(dout_valid),
    .dout_busy (dout_busy),
    .dout_data (dout_data),
    .sat_cnt   (sat_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the real line, floor of (x + half LSB) / 2^SH, then clip.
  function automatic int quant(input int x, output bit clip);
    real rnd;
    int  q;
    int  qmax;
    int  qmin;
    rnd  = (SH > 0) ? 2.0 ** (SH - 1) : 0.0;
    q    = $rtoi($floor((real'(x) + rnd) / (2.0 ** SH)));
    qmax = (1 << (OW - 1)) - 1;
    qmin = -(1 << (OW - 1));
    clip = 1'b0;
    if (q > qmax) begin
      q = qmax;
      clip = 1'b1;
    end else if (q < qmin) begin
      q = qmin;
      clip = 1'b1;
    end
    return q;
  endfunction

  int exp_q[$];
  int got[$];
  int mphs = 0;
  int msat = 0;

  // Scoreboard: looks at both handshakes mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    int  deff;
    int  v;
    bit  clip;
    if (rst) begin
      exp_q.delete();
      mphs = 0;
      msat = 0;
    end else begin
      check("inflight_le_depth", (exp_q.size() <= FD) ? 1 : 0, 1);
      if (dout_valid && !dout_busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d, expected no output (t=%0t)", $signed(dout_data), $time);
        end else begin
          check("dout_data_model", $signed(dout_data), exp_q.pop_front());
        end
        got.push_back(int'($signed(dout_data)));
      end
      if (din_valid && !din_busy) begin
        deff = (decim == 0) ? 1 : int'(decim);
        if (mphs >= deff) begin
          mphs = 0;
        end else begin
          if (mphs == 0) begin
            v = quant(int'($signed(din_data)), clip);
            exp_q.push_back(v);
            if (clip) msat++;
          end
          mphs = (mphs + 1 >= deff) ? 0 : mphs + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !dout_valid) return;
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain_timeout: %0d samples still pending, expected 0", exp_q.size());
  endtask

  // Offer din 64*k continuously, advancing k only on an accepted cycle.
  task automatic stream_seq(input int first, input int last, input bit toggle, input int budget);
    int  k;
    int  cyc;
    bit  acc;
    k = first;
    cyc = 0;
    while (k <= last && cyc < budget) begin
      din_valid = 1'b1;
      din_data  = IW'(64 * k);
      if (toggle) dout_busy = ~dout_busy;
      @(negedge clk);
      acc = !din_busy;
      @(posedge clk);
      #1;
      if (acc) k++;
      cyc++;
    end
    din_valid = 1'b0;
    if (k <= last) begin
      n_checks++;
      n_fail++;
      $display("FAIL stream_timeout: reached k=%0d, expected %0d", k, last + 1);
    end
  endtask

  typedef struct {
    int din;
    int dout;
    int sat;
  } vec_t;

  vec_t tv[13];

  initial begin
    int  k;
    int  n_acc;
    bit  acc;

    tv[0]  = '{64,       1,    0};
    tv[1]  = '{32,       1,    0};
    tv[2]  = '{31,       0,    0};
    tv[3]  = '{-32,      0,    0};
    tv[4]  = '{-33,      -1,   0};
    tv[5]  = '{8191,     127,  1};
    tv[6]  = '{-8300,    -128, 2};
    tv[7]  = '{8127,     127,  2};
    tv[8]  = '{-8224,    -128, 2};
    tv[9]  = '{-8225,    -128, 3};
    tv[10] = '{8160,     127,  4};
    tv[11] = '{2097151,  127,  5};
    tv[12] = '{-2097152, -128, 6};

    rst = 1'b1; decim = CW'(1); din_valid = 1'b0; din_data = '0; dout_busy = 1'b0;
    repeat (3) tick();
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_data", dout_data, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_din_busy", din_busy, 0);
    rst = 1'b0;
    tick();

    // Single samples, D=1: rounding, saturation edges, and two-cycle latency.
    foreach (tv[i]) begin
      din_data  = IW'(tv[i].din);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      check("lat_n1_not_valid", dout_valid, 0);
      tick();
      check("lat_n2_valid", dout_valid, 1);
      check("vec_dout", $signed(dout_data), tv[i].dout);
      check("vec_sat_cnt", sat_cnt, tv[i].sat);
      tick();
    end

    // Decimation by 3, then decim=0 behaving as 1.
    got.delete();
    decim = CW'(3);
    for (int j = 1; j <= 9; j++) begin
      din_data = IW'(64 * j);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    drain(50);
    check("dec3_count", got.size(), 3);
    if (got.size() == 3) begin
      check("dec3_0", got[0], 1);
      check("dec3_1", got[1], 4);
      check("dec3_2", got[2], 7);
    end
    got.delete();
    decim = CW'(0);
    din_data = IW'(64);  din_valid = 1'b1; tick();
    din_data = IW'(128); tick();
    din_valid = 1'b0;
    drain(50);
    check("dec0_count", got.size(), 2);
    if (got.size() == 2) begin
      check("dec0_0", got[0], 1);
      check("dec0_1", got[1], 2);
    end
    check("sat_cnt_model_a", sat_cnt, msat);

    // Held backpressure: four accepts fill FIFO + stage 1, head stays put.
    got.delete();
    decim = CW'(1);
    dout_busy = 1'b1;
    k = 1;
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      din_valid = 1'b1;
      din_data  = IW'(64 * k);
      @(negedge clk);
      acc = !din_busy;
      if (acc) n_acc++;
      if (dout_valid) check("hold_head", $signed(dout_data), 1);
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    check("bp_accepts", n_acc, FD);
    check("bp_din_busy", din_busy, 1);
    dout_busy = 1'b0;
    stream_seq(k, 20, 1'b0, 200);
    drain(50);
    check("bp_count", got.size(), 20);
    foreach (got[i]) check("bp_seq", got[i], i + 1);

    // Toggling backpressure with continuous input.
    got.delete();
    stream_seq(1, 30, 1'b1, 400);
    dout_busy = 1'b0;
    drain(50);
    check("tog_count", got.size(), 30);
    foreach (got[i]) check("tog_seq", got[i], i + 1);

    // Random traffic, full-range and small data, decim changes mid-stream.
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) decim = CW'($urandom_range(0, 15));
      din_valid = ($urandom_range(0, 3) != 0);
      din_data  = ($urandom_range(0, 1) == 1) ? IW'($urandom) : IW'($urandom_range(0, 16383) - 8192);
      dout_busy = ($urandom_range(0, 2) == 0);
      tick();
    end
    din_valid = 1'b0;
    dout_busy = 1'b0;
    drain(100);
    check("sat_cnt_model_rand", sat_cnt, msat);

    // Reset mid-operation: 3 buffered samples, phs=1, input offered during reset.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    decim = CW'(2);
    dout_busy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      din_data  = (j == 0) ? IW'(100000) : IW'(64 * (j + 1));
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", dout_valid, 1);
    check("pre_rst_sat", sat_cnt, 1);
    check("pre_rst_busy", din_busy, 0);
    rst = 1'b1;
    din_valid = 1'b1;
    din_data  = IW'(64);
    tick();
    rst = 1'b0;
    din_valid = 1'b0;
    check("post_rst_valid", dout_valid, 0);
    check("post_rst_sat", sat_cnt, 0);
    check("post_rst_busy", din_busy, 0);
    dout_busy = 1'b0;
    din_data  = IW'(64 * 7);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    check("post_rst_kept_valid", dout_valid, 1);
    check("post_rst_kept_data", $signed(dout_data), 7);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
